// File: rtl/safe_mode_seq_pkg.sv
// safe_mode_seq_pkg
//   Shared types for the safe-mode switch sequencer: FSM state encoding,
//   the committed-configuration record and a one-hot helper.
package safe_mode_seq_pkg;

    // Upper bound on cluster size; cfg_t carries the master field at this
    // width and the sequencer uses the low NCORES bits (upper bits stay 0).
    localparam int unsigned MAX_CORES = 8;

    localparam logic CFG_TMR = 1'b0;
    localparam logic CFG_DMR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CS,
        HALT,
        SYNC,
        APPLY,
        RELEASE,
        ABORT
    } state_t;

    typedef struct packed {
        logic [MAX_CORES-1:0] master;
        logic                 safe_mode;
        logic                 conf;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{master: MAX_CORES'(1), safe_mode: 1'b0, conf: CFG_TMR};

    function automatic logic onehot(input logic [MAX_CORES-1:0] v);
        return (v != '0) && ((v & (v - MAX_CORES'(1))) == '0);
    endfunction

endpackage

// File: rtl/safe_mode_seq.sv
// safe_mode_seq
//   Applies a requested master-core / safe-mode / configuration change
//   safely: defers while a critical section is open, halts all cores,
//   triggers a master-to-shadow state sync, commits, then releases.
// Ports:
//   clk_i, rst_i (async, active-high)
//   master_core_i, safe_mode_i, safe_configuration_i : requested config
//   critical_section_i : software critical section open
//   halted_i, sync_done_i : core halt status / state-sync finished pulse
//   debug_req_o, sync_start_o : per-core halt request / sync start pulse
//   applied_master_o, applied_safe_mode_o, applied_config_o : committed config
//   busy_o, switch_done_o, timeout_o, req_invalid_o : status
module safe_mode_seq
    import safe_mode_seq_pkg::*;
#(
    parameter int unsigned      NCORES  = 3,
    parameter int unsigned      TO_W    = 16,
    parameter logic [TO_W-1:0]  TIMEOUT = TO_W'(1023)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCORES-1:0] master_core_i,
    input  logic              safe_mode_i,
    input  logic              safe_configuration_i,
    input  logic              critical_section_i,
    input  logic [NCORES-1:0] halted_i,
    input  logic              sync_done_i,
    output logic [NCORES-1:0] debug_req_o,
    output logic              sync_start_o,
    output logic [NCORES-1:0] applied_master_o,
    output logic              applied_safe_mode_o,
    output logic              applied_config_o,
    output logic              busy_o,
    output logic              switch_done_o,
    output logic              timeout_o,
    output logic              req_invalid_o
);

    state_t            r_state;
    logic [TO_W-1:0]   r_cnt;
    cfg_t              r_snap;
    cfg_t              r_fail_snap;
    cfg_t              r_applied;
    logic [NCORES-1:0] r_debug_req;
    logic              r_sync_start;
    logic              r_busy;
    logic              r_switch_done;
    logic              r_timeout;

    cfg_t              w_req;
    logic              w_valid;
    logic              w_pending;
    logic              w_all_halted;
    logic              w_all_running;

    always_comb begin
        w_req                     = '0;
        w_req.master[NCORES-1:0]  = master_core_i;
        w_req.safe_mode           = safe_mode_i;
        w_req.conf                = safe_configuration_i;
    end

    assign w_valid       = onehot(w_req.master);
    assign w_pending     = w_valid && (w_req != r_applied) && (w_req != r_fail_snap);
    assign w_all_halted  = &halted_i;
    assign w_all_running = ~|halted_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_snap        <= CFG_RESET;
            r_fail_snap   <= CFG_RESET;
            r_applied     <= CFG_RESET;
            r_debug_req   <= '0;
            r_sync_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_switch_done <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_sync_start  <= 1'b0;
            r_switch_done <= 1'b0;
            if ((r_state == HALT || r_state == SYNC) && r_cnt != '1) begin
                r_cnt <= r_cnt + TO_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_pending) begin
                        r_snap <= w_req;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (critical_section_i) begin
                            r_state <= WAIT_CS;
                        end else begin
                            r_state     <= HALT;
                            r_debug_req <= '1;
                        end
                    end
                end
                WAIT_CS: begin
                    // Any request that would not be accepted from IDLE
                    // (including one reverting to applied) abandons the wait.
                    if (!w_pending) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!critical_section_i) begin
                        r_state     <= HALT;
                        r_snap      <= w_req;
                        r_debug_req <= '1;
                        r_cnt       <= '0;
                    end
                end
                HALT: begin
                    if (w_all_halted) begin
                        r_state      <= SYNC;
                        r_sync_start <= 1'b1;
                        r_cnt        <= '0;
                    end else if (r_cnt == TIMEOUT) begin
                        r_state <= ABORT;
                        r_cnt   <= '0;
                    end
                end
                SYNC: begin
                    if (sync_done_i) begin
                        r_state <= APPLY;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT) begin
                        r_state <= ABORT;
                        r_cnt   <= '0;
                    end
                end
                APPLY: begin
                    r_applied   <= r_snap;
                    // Equal to the new applied value, so it can never block a request.
                    r_fail_snap <= r_snap;
                    r_timeout   <= 1'b0;
                    r_debug_req <= '0;
                    r_state     <= RELEASE;
                    r_cnt       <= '0;
                end
                RELEASE: begin
                    if (w_all_running) begin
                        r_state       <= IDLE;
                        r_switch_done <= 1'b1;
                        r_busy        <= 1'b0;
                        r_cnt         <= '0;
                    end
                end
                ABORT: begin
                    r_debug_req <= '0;
                    r_timeout   <= 1'b1;
                    r_fail_snap <= r_snap;
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_cnt       <= '0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_debug_req <= '0;
                    r_busy      <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign debug_req_o         = r_debug_req;
    assign sync_start_o        = r_sync_start;
    assign applied_master_o    = r_applied.master[NCORES-1:0];
    assign applied_safe_mode_o = r_applied.safe_mode;
    assign applied_config_o    = r_applied.conf;
    assign busy_o              = r_busy;
    assign switch_done_o       = r_switch_done;
    assign timeout_o           = r_timeout;
    assign req_invalid_o       = !w_valid;

endmodule

// File: tb/tb_safe_mode_seq.sv
// tb_safe_mode_seq
//   Self-checking bench for safe_mode_seq: reset values, invalid-request
//   table, hand-written multi-cycle sequences and a randomized phase
//   checked against a transaction-level model.
module tb_safe_mode_seq;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [2:0] master_core_i;
    logic       safe_mode_i;
    logic       safe_configuration_i;
    logic       critical_section_i;
    logic [2:0] halted_i;
    logic       sync_done_i;
    logic [2:0] debug_req_o;
    logic       sync_start_o;
    logic [2:0] applied_master_o;
    logic       applied_safe_mode_o;
    logic       applied_config_o;
    logic       busy_o;
    logic       switch_done_o;
    logic       timeout_o;
    logic       req_invalid_o;

    safe_mode_seq #(.NCORES(3), .TO_W(16), .TIMEOUT(16'd8)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .master_core_i       (master_core_i),
        .safe_mode_i         (safe_mode_i),
        .safe_configuration_i(safe_configuration_i),
        .critical_section_i  (critical_section_i),
        .halted_i            (halted_i),
        .sync_done_i         (sync_done_i),
        .debug_req_o         (debug_req_o),
        .sync_start_o        (sync_start_o),
        .applied_master_o    (applied_master_o),
        .applied_safe_mode_o (applied_safe_mode_o),
        .applied_config_o    (applied_config_o),
        .busy_o              (busy_o),
        .switch_done_o       (switch_done_o),
        .timeout_o           (timeout_o),
        .req_invalid_o       (req_invalid_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    int n_ss     = 0;

    // Environment knobs: per-core halt/release delay, stuck core, sync delay/stall.
    int core_dly [3] = '{2, 2, 2};
    bit core_stuck [3] = '{0, 0, 0};
    int sync_dly   = 2;
    bit sync_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (switch_done_o) n_done++;
        if (sync_start_o) n_ss++;
    endtask

    task automatic set_req(input logic [2:0] m, input logic s, input logic c);
        master_core_i        = m;
        safe_mode_i          = s;
        safe_configuration_i = c;
    endtask

    function automatic logic [4:0] applied();
        return {applied_master_o, applied_safe_mode_o, applied_config_o};
    endfunction

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            tick();
            if (!busy_o) break;
        end
        if (i == 300) begin
            n_checks++; n_err++;
            $display("FAIL %s: busy_o still 1 after 300 cycles, expected 0", name);
        end
    endtask

    task automatic wait_cores_free();
        int i;
        for (i = 0; i < 50; i++) begin
            if (halted_i == 3'b000) break;
            tick();
        end
        if (i == 50) begin
            n_checks++; n_err++;
            $display("FAIL cores_free: halted_i=%0b expected 000", halted_i);
        end
    endtask

    // Core model: each core follows debug_req_o after its own delay.
    initial begin
        int cnt [3];
        halted_i = '0;
        cnt = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < 3; c++) begin
                if (debug_req_o[c] != halted_i[c] && !(debug_req_o[c] && core_stuck[c])) begin
                    cnt[c]++;
                    if (cnt[c] >= core_dly[c]) begin
                        halted_i[c] = debug_req_o[c];
                        cnt[c] = 0;
                    end
                end else begin
                    cnt[c] = 0;
                end
            end
        end
    end

    // State-sync engine model: pulses sync_done_i sync_dly cycles after start.
    initial begin
        int scnt;
        sync_done_i = 1'b0;
        scnt = -1;
        forever begin
            @(posedge clk);
            #2;
            sync_done_i = 1'b0;
            if (sync_start_o) scnt = sync_dly;
            else if (scnt > 0) scnt--;
            if (scnt == 0) begin
                if (!sync_stall) sync_done_i = 1'b1;
                scnt = -1;
            end
        end
    end

    typedef struct {
        logic [2:0] master;
        logic       exp_invalid;
        logic       exp_busy;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int t_sd, t_ap, t_sw, t_hl, d0, s0, cnt_busy;
        bit ok;
        logic [4:0] m_app, m_fail, req;
        bit m_fail_valid, m_timeout;

        vecs[0] = '{3'b000, 1'b1, 1'b0};
        vecs[1] = '{3'b011, 1'b1, 1'b0};
        vecs[2] = '{3'b101, 1'b1, 1'b0};
        vecs[3] = '{3'b110, 1'b1, 1'b0};
        vecs[4] = '{3'b111, 1'b1, 1'b0};
        vecs[5] = '{3'b001, 1'b0, 1'b0};

        rst_i = 1'b1;
        set_req(3'b001, 1'b0, 1'b0);
        critical_section_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // Reset state
        check("rst_debug_req", debug_req_o, 3'b000);
        check("rst_sync_start", sync_start_o, 0);
        check("rst_applied", applied(), 5'b001_0_0);
        check("rst_busy", busy_o, 0);
        check("rst_switch_done", switch_done_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_req_invalid", req_invalid_o, 0);

        // Invalid / no-op requests never leave IDLE
        for (int i = 0; i < 6; i++) begin
            set_req(vecs[i].master, 1'b0, 1'b0);
            #1;
            check($sformatf("tbl_invalid_%0b", vecs[i].master), req_invalid_o, vecs[i].exp_invalid);
            tick(); tick();
            check($sformatf("tbl_busy_%0b", vecs[i].master), busy_o, vecs[i].exp_busy);
        end

        // Basic switch with latency checks
        core_dly = '{3, 3, 3};
        sync_dly = 5;
        d0 = n_done; s0 = n_ss;
        t_sd = -1; t_ap = -1; t_sw = -1; t_hl = -1;
        set_req(3'b010, 1'b1, 1'b1);
        tick();
        check("basic_debug_rise", debug_req_o, 3'b111);
        check("basic_busy_rise", busy_o, 1);
        for (int i = 1; i < 200; i++) begin
            tick();
            if (sync_done_i && t_sd < 0) t_sd = i;
            if (applied() == 5'b010_1_1 && t_ap < 0) begin
                t_ap = i;
                check("basic_debug_fall_with_apply", debug_req_o, 3'b000);
            end
            if (t_ap >= 0 && halted_i == 3'b000 && t_hl < 0) t_hl = i;
            if (switch_done_o && t_sw < 0) t_sw = i;
            if (!busy_o) break;
        end
        check("basic_apply_latency", t_ap - t_sd, 1);
        check("basic_done_latency", t_sw - t_hl, 0);
        check("basic_applied", applied(), 5'b010_1_1);
        check("basic_done_pulses", n_done - d0, 1);
        check("basic_sync_pulses", n_ss - s0, 1);
        check("basic_timeout", timeout_o, 0);
        tick();
        check("basic_done_one_cycle", switch_done_o, 0);
        wait_cores_free();

        // Deferred by critical section
        core_dly = '{2, 2, 2};
        sync_dly = 2;
        critical_section_i = 1'b1;
        set_req(3'b100, 1'b0, 1'b0);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (debug_req_o != 3'b000 || !busy_o) ok = 0;
        end
        check("cs_hold_no_halt_busy", ok, 1);
        critical_section_i = 1'b0;
        tick();
        check("cs_drop_debug_rise", debug_req_o, 3'b111);
        wait_idle("cs_complete");
        check("cs_applied", applied(), 5'b100_0_0);
        wait_cores_free();

        // Timeout: core 2 never halts
        core_stuck[2] = 1;
        set_req(3'b001, 1'b1, 1'b0);
        cnt_busy = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!busy_o) break;
            cnt_busy++;
            if (cnt_busy == 10) check("to_timeout_late", timeout_o, 0);
        end
        check("to_busy_cycles", cnt_busy, 10);
        check("to_timeout_set", timeout_o, 1);
        check("to_applied_kept", applied(), 5'b100_0_0);
        check("to_debug_dropped", debug_req_o, 3'b000);
        ok = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy_o) ok = 0;
        end
        check("to_no_retry", ok, 1);
        check("to_sticky", timeout_o, 1);
        core_stuck[2] = 0;
        wait_cores_free();
        set_req(3'b001, 1'b1, 1'b1);
        wait_idle("to_retry");
        check("to_retry_applied", applied(), 5'b001_1_1);
        check("to_cleared", timeout_o, 0);
        wait_cores_free();

        // Request changed during SYNC: snapshot commits, then second switch
        sync_dly = 5;
        d0 = n_done; s0 = n_ss;
        set_req(3'b010, 1'b0, 1'b1);
        for (int i = 0; i < 100 && n_ss == s0; i++) tick();
        check("chg_sync_started", n_ss - s0, 1);
        set_req(3'b100, 1'b1, 1'b0);
        for (int i = 0; i < 100 && n_done == d0; i++) tick();
        check("chg_first_commit", applied(), 5'b010_0_1);
        tick();
        check("chg_back_to_back", busy_o, 1);
        wait_idle("chg_second");
        check("chg_second_commit", applied(), 5'b100_1_0);
        check("chg_done_pulses", n_done - d0, 2);
        wait_cores_free();

        // Asynchronous reset while in SYNC
        s0 = n_ss;
        set_req(3'b010, 1'b1, 1'b1);
        for (int i = 0; i < 100 && n_ss == s0; i++) tick();
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_debug", debug_req_o, 3'b000);
        check("arst_applied", applied(), 5'b001_0_0);
        check("arst_busy", busy_o, 0);
        check("arst_status", {sync_start_o, switch_done_o, timeout_o}, 3'b000);
        set_req(3'b001, 1'b0, 1'b0);
        tick(); tick();
        rst_i = 1'b0;
        repeat (4) tick();
        check("arst_idle_after", busy_o, 0);
        wait_cores_free();

        // Randomized transactions against a transaction-level model
        m_app = 5'b001_0_0; m_fail = '0; m_fail_valid = 0; m_timeout = 0;
        for (int t = 0; t < 40; t++) begin
            logic [2:0] m;
            bit valid, attempt, stall;
            int cs_hold;
            if ($urandom_range(0, 9) == 0) begin
                m = 3'($urandom_range(0, 7));
                if (m == 3'b001 || m == 3'b010 || m == 3'b100) m = 3'b011;
            end else begin
                m = 3'b001 << $urandom_range(0, 2);
            end
            req = {m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            valid   = ($countones(m) == 1);
            attempt = valid && (req != m_app) && !(m_fail_valid && req == m_fail);
            stall   = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 3; c++) core_dly[c] = $urandom_range(1, 4);
            sync_dly = $urandom_range(1, 4);
            if (stall) begin
                if ($urandom_range(0, 1) == 1) core_stuck[$urandom_range(0, 2)] = 1;
                else sync_stall = 1;
            end
            cs_hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            d0 = n_done;
            critical_section_i = (cs_hold > 0);
            set_req(req[4:2], req[1], req[0]);
            #1;
            check($sformatf("rnd%0d_req_invalid", t), req_invalid_o, !valid);
            ok = 1;
            for (int i = 0; i < cs_hold; i++) begin
                tick();
                if (debug_req_o != 3'b000 || busy_o != attempt) ok = 0;
            end
            if (cs_hold > 0) check($sformatf("rnd%0d_cs_defer", t), ok, 1);
            critical_section_i = 1'b0;
            wait_idle($sformatf("rnd%0d_idle", t));
            if (attempt) begin
                if (stall) begin
                    m_fail = req; m_fail_valid = 1; m_timeout = 1;
                end else begin
                    m_app = req; m_fail_valid = 0; m_timeout = 0;
                end
            end
            check($sformatf("rnd%0d_applied", t), applied(), m_app);
            check($sformatf("rnd%0d_timeout", t), timeout_o, m_timeout);
            check($sformatf("rnd%0d_done", t), n_done - d0, (attempt && !stall) ? 1 : 0);
            core_stuck = '{0, 0, 0};
            sync_stall = 0;
            wait_cores_free();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/safe_mode_seq.md
# safe_mode_seq

Safe-mode switch sequencer sitting directly downstream of the safe-wrapper control register block. It consumes the requested master core, safe-mode enable, configuration and critical-section flag, and applies a change safely:
- defers it while a critical section is open;
- halts every core through debug request and waits for all halt acks;
- triggers a master-to-shadow state sync;
- commits the new configuration, then releases the cores.

The voter/lockstep logic reads only the committed (`applied_*`) outputs, never the raw register values.

## Interface
Parameters:
- `NCORES`, 3, number of cores in the cluster; also the width of the one-hot master field.
- `TO_W`, 16, width of the timeout counter.
- `TIMEOUT`, 16'd1023, cycles allowed in HALT or SYNC before aborting.

Ports (clock and reset first):
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `master_core_i`  in  NCORES  requested master core, one-hot.
- `safe_mode_i`  in  1  requested safe-mode enable.
- `safe_configuration_i`  in  1  requested configuration: 0 = TMR, 1 = DMR.
- `critical_section_i`  in  1  software critical section open.
- `halted_i`  in  NCORES  per-core halted status.
- `sync_done_i`  in  1  one-cycle pulse: state sync finished.
- `debug_req_o`  out  NCORES  per-core halt request.
- `sync_start_o`  out  1  one-cycle pulse that starts the state sync.
- `applied_master_o`  out  NCORES  committed master core.
- `applied_safe_mode_o`  out  1  committed safe-mode enable.
- `applied_config_o`  out  1  committed configuration.
- `busy_o`  out  1  FSM not in IDLE.
- `switch_done_o`  out  1  one-cycle pulse: switch completed.
- `timeout_o`  out  1  sticky: last switch was aborted.
- `req_invalid_o`  out  1  `master_core_i` is not one-hot.

## Operation
- **Request.** `req = {master_core_i, safe_mode_i, safe_configuration_i}`. A pending request exists when `req != applied`, `master_core_i` is one-hot, and `req != fail_snap`.
- **IDLE.**
  - Pending and `critical_section_i = 1` → WAIT_CS.
  - Pending and `critical_section_i = 0` → HALT.
  - On leaving IDLE, `req` is latched into `snap`.
- **WAIT_CS.**
  - `critical_section_i = 0` → HALT; `snap` is re-latched from the current `req`.
  - `req` becomes equal to `applied` → IDLE.
- **HALT.**
  - `debug_req_o` = all ones.
  - All `halted_i` high → SYNC.
  - Counter reaches `TIMEOUT` → ABORT.
- **SYNC.**
  - `sync_start_o` pulses in the first cycle only.
  - `sync_done_i` → APPLY.
  - Counter reaches `TIMEOUT` → ABORT.
- **APPLY.** One cycle: `applied_* <= snap`, `fail_snap` cleared, `timeout_o` cleared → RELEASE.
- **RELEASE.**
  - `debug_req_o` = 0.
  - All `halted_i` low → IDLE, with `switch_done_o` = 1 in that transition cycle.
  - No timeout in this state.
- **ABORT.** One cycle: `debug_req_o` dropped, `timeout_o` set, `fail_snap <= snap`, `applied_*` unchanged → IDLE.
  - A retry happens only once `req` differs from `fail_snap`.
- **Input changes in HALT/SYNC** are ignored; only `snap` is used. A remaining mismatch re-triggers from IDLE.
- **Critical section after HALT entry** is ignored.
- **Counter.** Cleared on every state entry. Increments in HALT and SYNC, saturating at all ones.
- **`sync_done_i` outside SYNC** is ignored.
- **Invalid request.** `req_invalid_o = !onehot(master_core_i)`, combinational. An invalid request never leaves IDLE.

## Timing
- **Reset values:** state IDLE; `applied_master_o` = `'b1` (core 0); `applied_safe_mode_o` = 0; `applied_config_o` = 0; `debug_req_o` = 0; `sync_start_o` = 0; `busy_o` = 0; `switch_done_o` = 0; `timeout_o` = 0; `snap` = `fail_snap` = reset values of `applied_*`.
- **Registered outputs:** all outputs except `req_invalid_o` are registered.
- **Latency, best case:** request differs at cycle N; `debug_req_o` high at N+1; halts seen at M → `sync_start_o` at M+1; `sync_done_i` at K → APPLY at K+1; `applied_*` updated and `debug_req_o` low at K+2; halts drop at L → `switch_done_o` at L+1 together with `busy_o` = 0.
- **Timeout:** abort occurs when the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after HALT/SYNC entry; `timeout_o` is visible one cycle later.
- **Reset mid-sequence:** asynchronous return to reset values. `debug_req_o` drops immediately and the committed configuration reverts to its default.

## Structure
- **`safe_mode_seq_pkg`:**
  - state enum `{IDLE, WAIT_CS, HALT, SYNC, APPLY, RELEASE, ABORT}`;
  - `cfg_t` struct `{master, safe_mode, config}` used for `snap`, `fail_snap` and `applied`;
  - `onehot()` function;
  - configuration encoding localparams `CFG_TMR` = 0 and `CFG_DMR` = 1.
- **Sub-modules:** none; single module with the FSM, counter and `cfg_t` registers.

## Test plan
- Reset, then request master `3'b010`, safe = 1, DMR, with halts acked after 3 cycles and `sync_done_i` after 5 → `applied` = `{010,1,1}`, one `switch_done_o` pulse, `timeout_o` = 0.
- Request while `critical_section_i` = 1 for 20 cycles → `debug_req_o` stays 0 and `busy_o` = 1; `debug_req_o` rises 1 cycle after critical section drops.
- Core 2 never halts, `TIMEOUT` = 8 → ABORT after 9 HALT cycles, `timeout_o` = 1, `applied` unchanged, no retry; changing `req` → new attempt starts and success clears `timeout_o`.
- `master_core_i` = `3'b011` → `req_invalid_o` = 1, FSM stays IDLE.
- Change `req` during SYNC → the first switch commits the snapshot, then a second switch runs back-to-back.
- Assert `rst_i` while in SYNC → all outputs at reset values in the same cycle.
